// File: rtl/ldpc_pkg.sv
// ldpc_pkg: CCSDS (1536,1024) LDPC code sizes and arbiter state encoding.
package ldpc_pkg;
    localparam int LDPC_N = 1536;
    localparam int LDPC_K = 1024;
    localparam int LDPC_M = 512;
    typedef enum logic {
        ARB  = 1'b0,
        FEED = 1'b1
    } state_t;
endpackage

// File: rtl/ldpc_id_fifo.sv
// ldpc_id_fifo: 2-deep sync FIFO of channel IDs; head reads 0 when empty.
module ldpc_id_fifo #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);
    logic [W-1:0] r_mem [2];
    logic         r_rd;
    logic         r_wr;
    logic [1:0]   r_cnt;
    logic         w_push;
    logic         w_pop;
    assign o_full  = r_cnt == 2'd2;
    assign o_empty = r_cnt == 2'd0;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = o_empty ? '0 : r_mem[r_rd];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= ~r_wr;
            end
            if (w_pop) r_rd <= ~r_rd;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: rtl/ldpc_enc_arbiter.sv
// ldpc_enc_arbiter: frame-level round-robin sharing of one bit-serial LDPC encoder
// among NUM_CH sources, with channel-ID tagging of the codeword stream.
module ldpc_enc_arbiter
    import ldpc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int K      = LDPC_K,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic [NUM_CH-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0] s_axis_tvalid,
    output logic [NUM_CH-1:0] s_axis_tready,
    output logic              enc_s_tdata,
    output logic              enc_s_tvalid,
    input  logic              enc_s_tready,
    input  logic              enc_m_tdata,
    input  logic              enc_m_tvalid,
    input  logic              enc_m_tlast,
    output logic              enc_m_tready,
    output logic              m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    output logic [CH_W-1:0]   m_axis_tuser,
    input  logic              m_axis_tready,
    output logic [CH_W-1:0]   grant_id,
    output logic              busy
);
    localparam int CNT_W = $clog2(K);
    state_t            r_state;
    state_t            w_next;
    logic [CH_W-1:0]   r_grant_id;
    logic [CH_W-1:0]   r_last;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [NUM_CH-1:0] w_req;
    logic [CH_W-1:0]   w_idx;
    logic [CH_W-1:0]   w_pick;
    logic              w_found;
    logic              w_full;
    logic              w_empty;
    logic              w_grant;
    logic              w_feed_hs;
    logic              w_pop;
    assign w_req     = s_axis_tvalid & ch_enable;
    assign w_grant   = (r_state == ARB) & w_found & ~w_full;
    assign w_feed_hs = enc_s_tvalid & enc_s_tready;
    assign w_pop     = enc_m_tvalid & m_axis_tready & enc_m_tlast;
    assign grant_id  = r_grant_id;
    // Walk the channels starting just after the last grant; first requester wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = r_last;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = (w_idx == CH_W'(NUM_CH - 1)) ? '0 : w_idx + 1'b1;
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end
    always_ff @(posedge clk) begin
        r_state <= !rst_n ? ARB : w_next;
    end
    always_comb begin
        w_next = (r_state == ARB) ? (w_grant ? FEED : ARB)
               : ((w_feed_hs && r_bit_cnt == CNT_W'(K - 1)) ? ARB : FEED);
    end
    always_comb begin
        busy          = r_state == FEED;
        enc_s_tvalid  = busy & s_axis_tvalid[r_grant_id];
        enc_s_tdata   = busy & s_axis_tdata[r_grant_id];
        s_axis_tready = busy ? (NUM_CH'(enc_s_tready) << r_grant_id) : '0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant_id <= '0;
            r_last     <= CH_W'(NUM_CH - 1);
            r_bit_cnt  <= '0;
        end else if (w_grant) begin
            r_grant_id <= w_pick;
            r_last     <= w_pick;
            r_bit_cnt  <= '0;
        end else if (w_feed_hs) begin
            r_bit_cnt  <= r_bit_cnt + 1'b1;
        end
    end
    // A second entry lets the next frame be granted while the previous codeword's parity drains.
    ldpc_id_fifo #(.W(CH_W)) u_id_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_grant),
        .i_pop  (w_pop),
        .i_din  (w_pick),
        .o_full (w_full),
        .o_empty(w_empty),
        .o_head (m_axis_tuser)
    );
    assign m_axis_tdata  = enc_m_tdata;
    assign m_axis_tvalid = enc_m_tvalid;
    assign m_axis_tlast  = enc_m_tlast;
    assign enc_m_tready  = m_axis_tready;
endmodule

// File: tb/tb_ldpc_enc_arbiter.sv
// tb_ldpc_enc_arbiter: randomized scenarios against a frame-level arbitration model,
// with a behavioural buffered encoder standing in for the core.
module tb_ldpc_enc_arbiter;
    import ldpc_pkg::*;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int K      = LDPC_K;
    localparam int N      = LDPC_N;
    localparam int M      = LDPC_M;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NUM_CH-1:0] ch_enable = '1;
    logic [NUM_CH-1:0] s_axis_tdata, s_axis_tvalid, s_axis_tready;
    logic enc_s_tdata, enc_s_tvalid, enc_s_tready;
    logic enc_m_tdata, enc_m_tvalid, enc_m_tlast, enc_m_tready;
    logic m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [CH_W-1:0] m_axis_tuser, grant_id;
    logic busy;

    int vectors = 0;
    int miscompares = 0;
    int budget[NUM_CH];
    int acc[NUM_CH];
    int gap_ch = -1, gap_at = 0, gap_len = 0, gap_cnt = 0;
    bit rnd_gaps = 0, rnd_ready = 0, rnd_enc = 0, ready_force = 1;
    int grant_log[$];
    int tag_log[$];
    int last_log[$];
    int out_beats = 0;

    always #5 clk = ~clk;

    ldpc_enc_arbiter #(.NUM_CH(NUM_CH), .K(K), .CH_W(CH_W)) dut (
        .clk(clk), .rst_n(rst_n), .ch_enable(ch_enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .enc_s_tdata(enc_s_tdata), .enc_s_tvalid(enc_s_tvalid), .enc_s_tready(enc_s_tready),
        .enc_m_tdata(enc_m_tdata), .enc_m_tvalid(enc_m_tvalid), .enc_m_tlast(enc_m_tlast),
        .enc_m_tready(enc_m_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .grant_id(grant_id), .busy(busy)
    );

    // Sources: each channel offers budget[i] frames, optionally with a scripted gap or random gaps.
    initial begin
        bit gap;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            budget[i] = 0;
            acc[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) begin
                gap = (i == gap_ch) && (acc[i] >= gap_at) && (gap_cnt < gap_len);
                if (gap) gap_cnt++;
                s_axis_tvalid[i] = (acc[i] < budget[i] * K) && !gap && (!rnd_gaps || $urandom_range(3) != 0);
                s_axis_tdata[i]  = 1'($urandom);
            end
            m_axis_tready = rnd_ready ? ($urandom_range(3) != 0) : ready_force;
        end
    end

    // Encoder stand-in: one input frame buffer plus one output codeword buffer.
    initial begin
        bit ib[K];
        bit ob[N];
        int ib_cnt, ob_cnt;
        bit ob_act;
        ib_cnt = 0; ob_cnt = 0; ob_act = 0;
        enc_s_tready = 1'b0; enc_m_tvalid = 1'b0; enc_m_tdata = 1'b0; enc_m_tlast = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                ib_cnt = 0; ob_cnt = 0; ob_act = 0;
            end else begin
                if (enc_s_tvalid && enc_s_tready) begin
                    ib[ib_cnt] = enc_s_tdata;
                    ib_cnt++;
                end
                if (enc_m_tvalid && enc_m_tready) begin
                    ob_cnt++;
                    if (ob_cnt == N) ob_act = 0;
                end
                if (!ob_act && ib_cnt == K) begin
                    for (int j = 0; j < K; j++) ob[j] = ib[j];
                    for (int j = 0; j < M; j++) ob[K+j] = ib[j] ^ ib[j+M];
                    ob_act = 1; ob_cnt = 0; ib_cnt = 0;
                end
            end
            @(negedge clk);
            enc_s_tready = (ib_cnt < K) && (!rnd_enc || $urandom_range(3) != 0);
            enc_m_tvalid = ob_act;
            enc_m_tdata  = ob_act ? ob[ob_cnt] : 1'b0;
            enc_m_tlast  = ob_act && (ob_cnt == N - 1);
        end
    end

    // Reference model: round-robin frame grants, tag queue, and routing/pass-through checks.
    initial begin
        bit m_feed;
        int m_gid, m_last, m_bits, pick;
        int exp_q[$];
        logic [NUM_CH-1:0] req, exp_rdy;
        logic [CH_W-1:0] exp_tag;
        m_feed = 0; m_gid = 0; m_last = NUM_CH - 1; m_bits = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                m_feed = 0; m_gid = 0; m_last = NUM_CH - 1; m_bits = 0;
                exp_q.delete();
            end else begin
                vectors++;
                if (busy !== m_feed) begin
                    miscompares++;
                    $display("FAIL busy @%0t: got %b want %b", $time, busy, m_feed);
                end
                exp_rdy = (m_feed && enc_s_tready) ? (NUM_CH'(1) << m_gid) : '0;
                vectors++;
                if (s_axis_tready !== exp_rdy) begin
                    miscompares++;
                    $display("FAIL s_axis_tready @%0t: got %b want %b", $time, s_axis_tready, exp_rdy);
                end
                vectors++;
                if (m_feed && (grant_id !== CH_W'(m_gid) || enc_s_tvalid !== s_axis_tvalid[m_gid]
                               || enc_s_tdata !== s_axis_tdata[m_gid])) begin
                    miscompares++;
                    $display("FAIL feed_route @%0t: gid %0d v %b d %b want gid %0d v %b d %b", $time,
                             grant_id, enc_s_tvalid, enc_s_tdata, m_gid, s_axis_tvalid[m_gid], s_axis_tdata[m_gid]);
                end else if (!m_feed && enc_s_tvalid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL arb_enc_valid @%0t: got %b want 0", $time, enc_s_tvalid);
                end
                vectors++;
                if ({m_axis_tdata, m_axis_tvalid, m_axis_tlast, enc_m_tready}
                    !== {enc_m_tdata, enc_m_tvalid, enc_m_tlast, m_axis_tready}) begin
                    miscompares++;
                    $display("FAIL passthru @%0t: got %b want %b", $time,
                             {m_axis_tdata, m_axis_tvalid, m_axis_tlast, enc_m_tready},
                             {enc_m_tdata, enc_m_tvalid, enc_m_tlast, m_axis_tready});
                end
                exp_tag = (exp_q.size() > 0) ? CH_W'(exp_q[0]) : '0;
                vectors++;
                if (m_axis_tuser !== exp_tag) begin
                    miscompares++;
                    $display("FAIL tuser @%0t: got %0d want %0d", $time, m_axis_tuser, exp_tag);
                end
                if (m_axis_tvalid === 1'b1 && exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL protocol @%0t: output valid with no pending codeword", $time);
                end
                req = s_axis_tvalid & ch_enable;
                if (m_feed) begin
                    if (s_axis_tvalid[m_gid] && enc_s_tready) begin
                        acc[m_gid]++;
                        m_bits++;
                        if (m_bits == K) m_feed = 0;
                    end
                end else if (req != '0 && exp_q.size() < 2) begin
                    pick = -1;
                    for (int d = 1; d <= NUM_CH; d++)
                        if (pick < 0 && req[(m_last + d) % NUM_CH]) pick = (m_last + d) % NUM_CH;
                    m_gid = pick; m_last = pick; m_feed = 1; m_bits = 0;
                    exp_q.push_back(pick);
                    grant_log.push_back(pick);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (m_axis_tlast) begin
                        last_log.push_back(out_beats);
                        tag_log.push_back(int'(m_axis_tuser));
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                    end
                    out_beats++;
                end
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        ch_enable = '1;
        rnd_gaps = 0; rnd_ready = 0; rnd_enc = 0; ready_force = 1;
        gap_ch = -1; gap_cnt = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            budget[i] = 0;
            acc[i] = 0;
        end
        repeat (3) @(negedge clk);
        grant_log.delete(); tag_log.delete(); last_log.delete(); out_beats = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_grants(int n);
        int t = 0;
        while (grant_log.size() < n && t < 40000) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (grant_log.size() < n) begin
            miscompares++;
            $display("FAIL grant_wait: got %0d grants want %0d", grant_log.size(), n);
        end
    endtask

    task automatic wait_tags(int n);
        int t = 0;
        while (tag_log.size() < n && t < 40000) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (tag_log.size() < n) begin
            miscompares++;
            $display("FAIL tag_wait: got %0d codewords want %0d", tag_log.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NUM_CH; i++) budget[i] = 1;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({busy, grant_id, s_axis_tready, enc_s_tvalid, m_axis_tuser} !== {1'b0, 2'd0, 4'b0, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL reset_values: busy %b gid %0d rdy %b ev %b tuser %0d want 0 0 0000 0 0",
                     busy, grant_id, s_axis_tready, enc_s_tvalid, m_axis_tuser);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1 || grant_id !== 2'd0 || s_axis_tready !== {3'b0, enc_s_tready}) begin
            miscompares++;
            $display("FAIL first_grant: busy %b gid %0d rdy %b want 1 0 000%b", busy, grant_id, s_axis_tready, enc_s_tready);
        end
    endtask

    task automatic test_single_channel();
        reset_dut();
        budget[1] = 2;
        wait_tags(2);
        repeat (20) @(negedge clk);
        vectors++;
        if (grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 1) begin
            miscompares++;
            $display("FAIL single_grants: got %p want '{1,1}", grant_log);
        end
        vectors++;
        if (tag_log.size() != 2 || tag_log[0] != 1 || tag_log[1] != 1) begin
            miscompares++;
            $display("FAIL single_tags: got %p want '{1,1}", tag_log);
        end
        vectors++;
        if (out_beats != 2 * N || last_log.size() != 2 || last_log[0] != N - 1 || last_log[1] != 2 * N - 1) begin
            miscompares++;
            $display("FAIL single_tlast: beats %0d lasts %p want 3072 '{1535,3071}", out_beats, last_log);
        end
    endtask

    task automatic test_round_robin();
        int exp[5] = '{0, 1, 2, 3, 0};
        reset_dut();
        rnd_ready = 1;
        budget[0] = 2; budget[1] = 1; budget[2] = 1; budget[3] = 1;
        wait_tags(5);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (grant_log.size() <= i || grant_log[i] != exp[i] || tag_log[i] != exp[i]) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: grants %p tags %p want %0d", i, grant_log, tag_log, exp[i]);
            end
        end
        vectors++;
        if (last_log.size() != grant_log.size()) begin
            miscompares++;
            $display("FAIL rr_tlast_count: got %0d want %0d", last_log.size(), grant_log.size());
        end
    endtask

    task automatic test_valid_gap();
        int t = 0;
        reset_dut();
        budget[2] = 1;
        gap_ch = 2; gap_at = 500; gap_len = 50;
        wait_grants(1);
        budget[0] = 1;
        while (acc[2] < 500 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (50) begin
            @(negedge clk);
            #1;
            vectors++;
            if (grant_id !== 2'd2 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL gap_hold: gid %0d busy %b want 2 1", grant_id, busy);
            end
        end
        wait_tags(2);
        vectors++;
        if (grant_log.size() != 2 || grant_log[0] != 2 || grant_log[1] != 0 || tag_log[0] != 2 || tag_log[1] != 0) begin
            miscompares++;
            $display("FAIL gap_order: grants %p tags %p want '{2,0}", grant_log, tag_log);
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        ready_force = 0;
        budget[0] = 2; budget[1] = 2;
        repeat (2500) @(negedge clk);
        #1;
        vectors++;
        if (grant_log.size() != 2 || busy !== 1'b0 || s_axis_tready !== 4'b0 || grant_id !== 2'd1) begin
            miscompares++;
            $display("FAIL queue_full: grants %0d busy %b rdy %b gid %0d want 2 0 0000 1",
                     grant_log.size(), busy, s_axis_tready, grant_id);
        end
        vectors++;
        if (m_axis_tuser !== 2'd0 || m_axis_tvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL stalled_head: tuser %0d valid %b want 0 1", m_axis_tuser, m_axis_tvalid);
        end
        ready_force = 1;
        wait_tags(2);
        vectors++;
        if (tag_log[0] != 0 || tag_log[1] != 1) begin
            miscompares++;
            $display("FAIL release_tags: got %p want '{0,1,...}", tag_log);
        end
    endtask

    task automatic test_enable_mask();
        int exp[4] = '{0, 2, 0, 2};
        reset_dut();
        ch_enable = 4'b0101;
        rnd_ready = 1;
        for (int i = 0; i < NUM_CH; i++) budget[i] = 3;
        wait_tags(4);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (grant_log[i] != exp[i] || tag_log[i] != exp[i]) begin
                miscompares++;
                $display("FAIL enable_order[%0d]: grants %p tags %p want %0d", i, grant_log, tag_log, exp[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int t = 0;
        reset_dut();
        budget[1] = 1;
        while (acc[1] < 300 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        budget[0] = 1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if ({busy, grant_id, s_axis_tready, enc_s_tvalid, m_axis_tuser} !== {1'b0, 2'd0, 4'b0, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL midframe_reset: busy %b gid %0d rdy %b ev %b tuser %0d want 0 0 0000 0 0",
                     busy, grant_id, s_axis_tready, enc_s_tvalid, m_axis_tuser);
        end
        grant_log.delete();
        rst_n = 1'b1;
        wait_grants(1);
        vectors++;
        if (grant_log[0] != 0) begin
            miscompares++;
            $display("FAIL post_reset_grant: got %0d want 0", grant_log[0]);
        end
    endtask

    task automatic test_random();
        int total = 0;
        reset_dut();
        rnd_gaps = 1; rnd_ready = 1; rnd_enc = 1;
        for (int i = 0; i < NUM_CH; i++) begin
            budget[i] = $urandom_range(1);
            total += budget[i];
        end
        if (total < 2) begin
            budget[3] = 1; budget[1] = 1;
            total = budget[0] + budget[1] + budget[2] + 1;
        end
        wait_tags(total);
        vectors++;
        if (tag_log != grant_log || tag_log.size() != total) begin
            miscompares++;
            $display("FAIL random_tags: tags %p grants %p want %0d in grant order", tag_log, grant_log, total);
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_valid_gap();
        test_backpressure();
        test_enable_mask();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ldpc_enc_arbiter.md
# ldpc_enc_arbiter

Frame-level round-robin arbiter that shares one bit-serial CCSDS (1536,1024) LDPC encoder core among `NUM_CH` bit-serial AXI-Stream sources. Each grant is exactly one 1024-bit information block, never preempted. The block routes the granted source to the encoder input and passes the 1536-bit encoder output through to a single master stream. A `m_axis_tuser` channel ID tags every output bit. It sits between the per-channel framers and the encoder core.

## Interface
Parameters:
- `NUM_CH`, 4: number of source channels, 2..16.
- `K`, 1024: information bits per codeblock.
- `CH_W`, `$clog2(NUM_CH)`: channel ID width.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset. Synchronous and active-low, sampled on the rising edge of `clk`.
- `ch_enable`, in, `NUM_CH`: per-channel arbitration enable.
- `s_axis_tdata`, in, `NUM_CH`: one information bit per channel.
- `s_axis_tvalid`, in, `NUM_CH`: per-channel valid.
- `s_axis_tready`, out, `NUM_CH`: per-channel ready. At most one bit is high.
- `enc_s_tdata`, out, 1: to the encoder input.
- `enc_s_tvalid`, out, 1: to the encoder input.
- `enc_s_tready`, in, 1: from the encoder input.
- `enc_m_tdata`, in, 1: from the encoder output.
- `enc_m_tvalid`, in, 1: from the encoder output.
- `enc_m_tlast`, in, 1: from the encoder output.
- `enc_m_tready`, out, 1: to the encoder output.
- `m_axis_tdata`, out, 1: codeword bit.
- `m_axis_tvalid`, out, 1: codeword valid.
- `m_axis_tlast`, out, 1: high on codeword bit 1535.
- `m_axis_tuser`, out, `CH_W`: source channel of the current codeword.
- `m_axis_tready`, in, 1: downstream ready.
- `grant_id`, out, `CH_W`: channel currently being fed.
- `busy`, out, 1: high in FEED.

## Operation
State machine with two states, ARB and FEED.

ARB state:
- A channel requests when `s_axis_tvalid[i] & ch_enable[i]`.
- A grant is issued if any channel requests and the ID queue is not full.
- Round-robin search begins at `(last_grant+1) mod NUM_CH`. After reset, `last_grant` = `NUM_CH-1`, so channel 0 has first priority.
- On a grant: register `grant_id` and `last_grant`, push the ID into the queue, clear `bit_cnt`, go to FEED.
- All `s_axis_tready` bits are 0 in ARB, and `enc_s_tvalid` = 0.

FEED state:
- `enc_s_tdata` = `s_axis_tdata[grant_id]`.
- `enc_s_tvalid` = `s_axis_tvalid[grant_id]`.
- `s_axis_tready[grant_id]` = `enc_s_tready`; every other ready bit is 0.
- `bit_cnt` increments on each handshake. On the handshake at `bit_cnt` == K-1, return to ARB.
- Changes to `ch_enable` and `tvalid` gaps on the granted channel are ignored until the frame ends. There is no preemption and no timeout.

ID queue:
- Two-entry FIFO of channel IDs.
- Push on grant; pop on `m_axis_tvalid & m_axis_tready & m_axis_tlast`.
- `m_axis_tuser` = queue head.
- Two entries are required because the next grant can precede the last parity bit of the previous codeword. While the queue is full, no new grant is issued.
- Push and pop in the same cycle: count unchanged, head advances.

Output path is combinational pass-through with zero latency:
- `m_axis_tdata/tvalid/tlast` = `enc_m_*`.
- `enc_m_tready` = `m_axis_tready`.

Errors:
- If `enc_m_tvalid` is high while the queue is empty, `m_axis_tuser` = 0. The bench flags this as a protocol error.

## Timing
- Reset values: state ARB, `grant_id` = 0, `busy` = 0, queue empty, `bit_cnt` = 0. All `s_axis_tready` = 0, `enc_s_tvalid` = 0, `m_axis_tuser` = 0.
- Arbitration latency: a request seen in cycle t (in ARB) gives FEED and `s_axis_tready` in cycle t+1.
- Frame gap: after the K-th input handshake, ARB occupies one cycle before the next FEED. The encoder itself stalls input until its 512 parity bits drain.
- Back-to-back grants to the same channel are allowed if no other channel requests.
- `rst_n` low mid-frame: the next edge forces reset values and discards the partial frame. The encoder core shares `rst_n`, so both restart together.

## Structure
- Shared package `ldpc_pkg` holds `LDPC_N` = 1536, `LDPC_K` = 1024, `LDPC_M` = 512, and the state encoding constants `ARB`/`FEED`.
- Natural sub-module: `ldpc_id_fifo`, a 2-deep, `CH_W`-wide sync FIFO exposing push/pop/full/empty/head.
- The encoder core is instantiated by the parent, not inside this block.

## Test plan
- Single channel, `NUM_CH`=4, ch1 streams 2 frames:
  - ch1 granted twice.
  - 2×1536 output bits, `m_axis_tuser` = 1 throughout.
  - `tlast` on bits 1535 and 3071.
- All 4 channels continuously valid: grant order 0,1,2,3,0 with `m_axis_tuser` following the same sequence. `tlast` count equals grant count.
- ch2 drops `tvalid` for 50 cycles at bit 500 while ch0 requests: `grant_id` stays 2 until 1024 bits are accepted, then ch3 is skipped (idle) and ch0 is granted.
- `m_axis_tready` held low for 2000 cycles with ch0 and ch1 both requesting:
  - The queue fills at 2 entries and no third grant is issued.
  - After release, tags read 0 then 1.
- `ch_enable` = 4'b0101 with all channels valid: only ch0 and ch2 are ever granted, alternating.
- `rst_n` pulsed low at input bit 300 of ch1: next cycle shows ARB, `busy` = 0, queue empty, all ready bits 0. The next grant goes to ch0.
